multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Multicycle successor to the single-cycle RV32I main decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, with parametrised memory wait states and optional LUI/AUIPC support.
- Adds an IR write strobe, PC commit strobe, sticky illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register and the shared datapath (single ALU, unified memory).

Parameters:
- MEM_LAT, 1, memory access cycles per fetch/load/store (>=1).
- SUPPORT_UPPER, 1, 1: LUI/AUIPC legal; 0: they trap as illegal.
- CNT_W, 32, width of instr_count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- Opcode  in  7  opcode field of the instruction register.
- PCWrite  out  1  commit next PC this cycle.
- IRWrite  out  1  load instruction register.
- ALUSrcA  out  1  0: rs1; 1: PC (AUIPC).
- ALUSrc  out  1  0: rs2; 1: immediate.
- MemtoReg  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI).
- RegWrite  out  1  register file write enable.
- MemRead  out  1  memory read (fetch or load).
- MemWrite  out  1  memory write.
- ALUOp  out  2  00 add, 01 branch, 10 R/I-type, 11 jump.
- Branch  out  1  conditional PC update (datapath selects target or PC+4).
- Jump  out  1  JAL/JALR target select.
- Sel_jalr  out  1  target is ALU result (JALR).
- Illegal  out  1  sticky trap flag.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- instr_count  out  CNT_W  retired instruction count, wraps modulo 2^CNT_W.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset (async) forces state=IDLE, wait counter=0, latched class=none, instr_count=0. All outputs are 0 while in IDLE.
- Outputs are a Moore decode of state, latched opcode class and wait counter. Every output not listed for a state is 0.
- IDLE: -> FETCH next cycle, unconditionally.
- FETCH: MemRead=1 for MEM_LAT cycles; IRWrite=1 on the last one only; then -> DECODE.
- DECODE: latch the opcode class from Opcode.
  - Legal opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111; LUI 0110111 and AUIPC 0010111 only if SUPPORT_UPPER=1.
  - Legal -> EXEC; anything else -> TRAP.
  - Opcode changes after DECODE have no effect.
- EXEC, per class:
  - R: ALUOp=10, ALUSrc=0 -> WB.
  - I: ALUOp=10, ALUSrc=1 -> WB.
  - LW/SW: ALUOp=00, ALUSrc=1 -> MEM.
  - BR: ALUOp=01, Branch=1, PCWrite=1, instr_done=1 -> FETCH.
  - JAL: ALUOp=11, Jump=1 -> WB.
  - JALR: ALUOp=11, ALUSrc=1, Jump=1, Sel_jalr=1 -> WB.
  - LUI: no ALU use -> WB.
  - AUIPC: ALUOp=00, ALUSrcA=1, ALUSrc=1 -> WB.
- MEM: MemRead=1 (LW) or MemWrite=1 (SW) held for MEM_LAT cycles.
  - LW -> WB.
  - SW: PCWrite=1 and instr_done=1 on the last cycle -> FETCH.
- WB: RegWrite=1, PCWrite=1, instr_done=1 -> FETCH.
  - MemtoReg: 01 LW; 10 JAL/JALR; 11 LUI; else 00.
  - Jump and Sel_jalr are held as in EXEC so the PC mux is stable.
- TRAP: Illegal=1; no other strobes; remains in TRAP until reset.
- Wait counter: width $clog2(MEM_LAT+1); cleared on every entry to FETCH/MEM; last cycle when count==MEM_LAT-1. MEM_LAT=1 means a single-cycle state.
- Latencies (cycles from FETCH entry to retire pulse, inclusive):
  - R/I/JAL/JALR/LUI/AUIPC: MEM_LAT+3.
  - LW: 2*MEM_LAT+3.
  - SW: 2*MEM_LAT+2.
  - BR: MEM_LAT+2.
- instr_count increments on instr_done; wraps to 0 from all-ones.
- Reset asserted mid-instruction (including mid-MEM): immediate return to IDLE; a partial store has MemWrite deassert asynchronously.

Decomposition:
- ctrl_pkg:
  - opcode localparams;
  - state enum;
  - opclass enum (R, I, LW, SW, BR, JAL, JALR, LUI, AUIPC, ILL);
  - ALUOp and MemtoReg encodings.
- Sub-module op_decode: combinational Opcode + SUPPORT_UPPER -> opclass. It is shared with a future pipelined decoder.

Test Plan:
- MEM_LAT=1, R-type 0110011 after reset release -> IDLE, FETCH (MemRead, IRWrite), DECODE, EXEC (ALUOp=10), WB (RegWrite, PCWrite, MemtoReg=00); instr_done at cycle 4; instr_count=1.
- MEM_LAT=3, LW 0000011 -> MemRead high 3 cycles in FETCH and 3 in MEM; WB MemtoReg=01; retire at cycle 9. SW -> MemWrite 3 cycles, retire at cycle 8, RegWrite never asserted.
- BR 1100011 then JALR 1100111 -> BR: EXEC has Branch=1, PCWrite=1, ALUOp=01. JALR: Jump=Sel_jalr=1 in EXEC and WB, MemtoReg=10.
- SUPPORT_UPPER=0, LUI 0110111 -> TRAP, Illegal=1 sticky, no PCWrite over 20 cycles. Reset clears it. With SUPPORT_UPPER=1, LUI gives MemtoReg=11 and AUIPC gives ALUSrcA=1.
- Reset asserted during MEM of SW with MEM_LAT=4 -> MemWrite drops asynchronously; after release, IDLE then FETCH; instr_count=0.
- CNT_W=4, 17 back-to-back R-type instructions -> instr_count wraps to 1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle RV32I controller and its opcode
// decoder: opcode values, FSM state encoding, latched instruction class and
// the ALUOp / MemtoReg encodings seen by the datapath.
// No ports (package).
// ---------------------------------------------------------------------------
package ctrl_pkg;

    // RV32I major opcodes recognised by the controller
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    // CL_NONE is the post-reset value before any instruction was decoded
    typedef enum logic [3:0] {
        CL_NONE,
        CL_R,
        CL_I,
        CL_LW,
        CL_SW,
        CL_BR,
        CL_JAL,
        CL_JALR,
        CL_LUI,
        CL_AUIPC,
        CL_ILL
    } opclass_t;

    // ALUOp encodings
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RI     = 2'b10;
    localparam logic [1:0] ALUOP_JUMP   = 2'b11;

    // MemtoReg (write-back source) encodings
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

endpackage

// File: rtl/multicycle_controller_op_decode.sv
// ---------------------------------------------------------------------------
// op_decode
// Purely combinational classification of a 7-bit RV32I opcode into an
// instruction class. LUI/AUIPC are only recognised when SUPPORT_UPPER != 0,
// otherwise they classify as illegal. Kept standalone so a pipelined decoder
// can reuse it.
// Ports:
//   opcode  in   7-bit opcode field
//   opclass out  decoded instruction class (CL_ILL for anything unknown)
// ---------------------------------------------------------------------------
module op_decode
    import ctrl_pkg::*;
#(
    parameter int SUPPORT_UPPER = 1
) (
    input  logic [6:0] opcode,
    output opclass_t   opclass
);

    always_comb begin
        opclass = CL_ILL;
        case (opcode)
            OP_R:     opclass = CL_R;
            OP_I:     opclass = CL_I;
            OP_LW:    opclass = CL_LW;
            OP_SW:    opclass = CL_SW;
            OP_BR:    opclass = CL_BR;
            OP_JAL:   opclass = CL_JAL;
            OP_JALR:  opclass = CL_JALR;
            OP_LUI:   opclass = (SUPPORT_UPPER != 0) ? CL_LUI : CL_ILL;
            OP_AUIPC: opclass = (SUPPORT_UPPER != 0) ? CL_AUIPC : CL_ILL;
            default:  opclass = CL_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Multicycle RV32I main controller. Each instruction walks
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] with MEM_LAT-cycle memory
// accesses. Outputs are a Moore decode of (state, latched class, wait count),
// so every strobe drops as soon as the asynchronous reset hits the state.
// Parameters:
//   MEM_LAT        memory access cycles per fetch/load/store (>=1)
//   SUPPORT_UPPER  1: LUI/AUIPC legal, 0: they trap
//   CNT_W          width of instr_count
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   Opcode         opcode field of the instruction register
//   PCWrite        commit next PC
//   IRWrite        load instruction register
//   ALUSrcA        0 rs1, 1 PC
//   ALUSrc         0 rs2, 1 immediate
//   MemtoReg       00 ALU, 01 memory, 10 PC+4, 11 immediate
//   RegWrite       register file write enable
//   MemRead        memory read (fetch or load)
//   MemWrite       memory write
//   ALUOp          00 add, 01 branch, 10 R/I-type, 11 jump
//   Branch         conditional PC update
//   Jump           JAL/JALR target select
//   Sel_jalr       target is ALU result
//   Illegal        sticky illegal-opcode trap
//   instr_done     one-cycle retire pulse
//   instr_count    retired instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_LAT       = 1,
    parameter int SUPPORT_UPPER = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic             ALUSrc,
    output logic [1:0]       MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       ALUOp,
    output logic             Branch,
    output logic             Jump,
    output logic             Sel_jalr,
    output logic             Illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    localparam int                WAIT_W    = $clog2(MEM_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);

    state_t            state;
    state_t            state_next;
    opclass_t          opclass;
    opclass_t          decoded;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_last;

    op_decode #(
        .SUPPORT_UPPER(SUPPORT_UPPER)
    ) u_op_decode (
        .opcode (Opcode),
        .opclass(decoded)
    );

    assign wait_last = (wait_cnt == WAIT_LAST);

    // State register plus the small amount of state that rides with it.
    // FETCH and MEM never loop onto themselves once their last cycle is
    // reached, so any state change is exactly an "entry" that restarts the
    // wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            opclass     <= CL_NONE;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (state == S_FETCH || state == S_MEM) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            // Opcode is only sampled here; later changes are ignored
            if (state == S_DECODE) begin
                opclass <= decoded;
            end
            if (instr_done) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  if (wait_last) state_next = S_DECODE;
            S_DECODE: state_next = (decoded == CL_ILL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (opclass)
                    CL_LW, CL_SW: state_next = S_MEM;
                    CL_BR:        state_next = S_FETCH;
                    default:      state_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (wait_last) begin
                    state_next = (opclass == CL_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB:     state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrc     = 1'b0;
        MemtoReg   = WB_ALU;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUOp      = ALUOP_ADD;
        Branch     = 1'b0;
        Jump       = 1'b0;
        Sel_jalr   = 1'b0;
        Illegal    = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = wait_last;
            end
            S_EXEC: begin
                case (opclass)
                    CL_R: ALUOp = ALUOP_RI;
                    CL_I: begin
                        ALUOp  = ALUOP_RI;
                        ALUSrc = 1'b1;
                    end
                    CL_LW, CL_SW: begin
                        ALUOp  = ALUOP_ADD;
                        ALUSrc = 1'b1;
                    end
                    // Branches resolve here; the datapath picks target or PC+4
                    CL_BR: begin
                        ALUOp      = ALUOP_BRANCH;
                        Branch     = 1'b1;
                        PCWrite    = 1'b1;
                        instr_done = 1'b1;
                    end
                    CL_JAL: begin
                        ALUOp = ALUOP_JUMP;
                        Jump  = 1'b1;
                    end
                    CL_JALR: begin
                        ALUOp    = ALUOP_JUMP;
                        ALUSrc   = 1'b1;
                        Jump     = 1'b1;
                        Sel_jalr = 1'b1;
                    end
                    CL_AUIPC: begin
                        ALUOp   = ALUOP_ADD;
                        ALUSrcA = 1'b1;
                        ALUSrc  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                MemRead  = (opclass == CL_LW);
                MemWrite = (opclass == CL_SW);
                // A store retires on its final memory cycle (no WB)
                if (opclass == CL_SW && wait_last) begin
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                case (opclass)
                    CL_LW:           MemtoReg = WB_MEM;
                    CL_JAL, CL_JALR: MemtoReg = WB_PC4;
                    CL_LUI:          MemtoReg = WB_IMM;
                    default:         MemtoReg = WB_ALU;
                endcase
                // Keep the PC target mux stable while the PC commits
                Jump     = (opclass == CL_JAL) || (opclass == CL_JALR);
                Sel_jalr = (opclass == CL_JALR);
            end
            S_TRAP:  Illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
